// File: rtl/spaceship_laser.sv
// rtl/spaceship_laser.sv - player laser shot; optional re-fire lockout via SPACESHIP_LASER_COOLDOWN_EN
module spaceship_laser #(
    parameter logic [10:0] TOP_EDGE        = 11'd0,
    parameter logic [10:0] LASER_START_Y   = 11'd440,
    parameter logic [10:0] LASER_SPEED     = 11'd4,
    parameter logic [10:0] LASER_HEIGHT    = 11'd10,
    parameter logic [10:0] LASER_LENGTH    = 11'd3,
    parameter logic [10:0] PARK_Y          = 11'd2000,
`ifdef SPACESHIP_LASER_COOLDOWN_EN
    parameter logic [5:0]  COOLDOWN_FRAMES = 6'd20,
`endif
    parameter logic [7:0]  COLOR_LASER     = 8'b11111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [1:0]  mode,
    input  logic [9:0]  xCoord,
    input  logic [9:0]  yCoord,
    input  logic        fire,
    input  logic [10:0] spaceship_xCoord,
    input  logic        target_hit,
    output logic [10:0] laser_xCoord,
    output logic [10:0] laser_yCoord,
    output logic        laser_active,
    output logic        shot_fired,
    output logic        laser_hit,
    output logic        is_laser,
    output logic [7:0]  rgb
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLY  = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;
`ifdef SPACESHIP_LASER_COOLDOWN_EN
    localparam logic [1:0] S_COOL = 2'd3;
`endif

    // Retire threshold compared directly against y so the decrement never wraps.
    localparam logic [10:0] TOP_LIMIT = TOP_EDGE + LASER_SPEED + (LASER_HEIGHT >> 1);

    logic [1:0]  state;
    logic        fire_q;
    logic        fire_pending;
    logic        frame;
    logic        clear;
    logic        fire_edge;
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] dx;
    logic [10:0] dy;
`ifdef SPACESHIP_LASER_COOLDOWN_EN
    logic [5:0]  cool_cnt;
`endif

    assign frame        = (xCoord == 10'd0) && (yCoord == 10'd0);
    assign clear        = rst || restart || (mode != 2'd2);
    assign fire_edge    = fire && !fire_q;
    assign laser_active = (state == S_FLY);

    // Fire button history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (clear) fire_q <= 1'b0;
        else       fire_q <= fire;
    end

    // Shot state machine: launch, per-frame climb, retire on hit or top exit.
    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= S_IDLE;
            fire_pending <= 1'b0;
            laser_xCoord <= 11'd0;
            laser_yCoord <= PARK_Y;
            shot_fired   <= 1'b0;
            laser_hit    <= 1'b0;
`ifdef SPACESHIP_LASER_COOLDOWN_EN
            cool_cnt     <= 6'd0;
`endif
        end else begin
            shot_fired <= 1'b0;
            laser_hit  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame && fire_pending) begin
                        laser_xCoord <= spaceship_xCoord;
                        laser_yCoord <= LASER_START_Y;
                        fire_pending <= 1'b0;
                        shot_fired   <= 1'b1;
                        state        <= S_FLY;
                    end else if (fire_edge) begin
                        fire_pending <= 1'b1;
                    end
                end
                S_FLY: begin
                    if (frame) begin
                        if (target_hit) begin
                            laser_hit    <= 1'b1;
                            laser_yCoord <= PARK_Y;
                            state        <= S_END;
                        end else if (laser_yCoord < TOP_LIMIT) begin
                            laser_yCoord <= PARK_Y;
                            state        <= S_END;
                        end else begin
                            laser_yCoord <= laser_yCoord - LASER_SPEED;
                        end
                    end
                end
`ifdef SPACESHIP_LASER_COOLDOWN_EN
                S_END: begin
                    cool_cnt <= 6'd0;
                    state    <= S_COOL;
                end
                S_COOL: begin
                    if (frame) begin
                        if (cool_cnt == COOLDOWN_FRAMES - 6'd1) state <= S_IDLE;
                        else                                    cool_cnt <= cool_cnt + 6'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pixel membership test against the laser box, 11-bit unsigned distances.
    always_comb begin
        px       = {1'b0, xCoord};
        py       = {1'b0, yCoord};
        dx       = (px >= laser_xCoord) ? (px - laser_xCoord) : (laser_xCoord - px);
        dy       = (py >= laser_yCoord) ? (py - laser_yCoord) : (laser_yCoord - py);
        is_laser = laser_active && (dx <= (LASER_LENGTH >> 1)) && (dy <= (LASER_HEIGHT >> 1));
        rgb      = is_laser ? COLOR_LASER : 8'd0;
    end

endmodule

// File: tb/tb_spaceship_laser.sv
// tb/tb_spaceship_laser.sv - scoreboard bench for spaceship_laser
module tb_spaceship_laser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic [1:0]  mode = 2'd2;
    logic [9:0]  xc = 10'd100;
    logic [9:0]  yc = 10'd100;
    logic        fire = 1'b0;
    logic [10:0] ship_x = 11'd0;
    logic        target_hit = 1'b0;
    logic [10:0] laser_x;
    logic [10:0] laser_y;
    logic        laser_active;
    logic        shot_fired;
    logic        laser_hit;
    logic        is_laser;
    logic [7:0]  rgb;

    int n_tests = 0;
    int n_fail  = 0;
    logic [24:0] sb[$];

    spaceship_laser dut (
        .clk(clk), .rst(rst), .restart(restart), .mode(mode),
        .xCoord(xc), .yCoord(yc), .fire(fire),
        .spaceship_xCoord(ship_x), .target_hit(target_hit),
        .laser_xCoord(laser_x), .laser_yCoord(laser_y),
        .laser_active(laser_active), .shot_fired(shot_fired),
        .laser_hit(laser_hit), .is_laser(is_laser), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Expected output vector layout: {y, x, active, shot_fired, laser_hit}.
    function automatic logic [24:0] pk(input logic [10:0] y, input logic [10:0] x,
                                       input logic a, input logic s, input logic h);
        return {y, x, a, s, h};
    endfunction

    function automatic logic [24:0] got_vec();
        return {laser_y, laser_x, laser_active, shot_fired, laser_hit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One quiet cycle then one frame-tick cycle; outputs of the frame are visible on return.
    task automatic advance_frame();
        xc = 10'd100; yc = 10'd100;
        tick();
        xc = 10'd0; yc = 10'd0;
        tick();
        xc = 10'd100; yc = 10'd100;
    endtask

    task automatic fire_pulse();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
    endtask

    task automatic settle();
`ifdef SPACESHIP_LASER_COOLDOWN_EN
        repeat (20) advance_frame();
`else
        tick();
`endif
    endtask

    // Pushes the expected state of one frame and compares it after the DUT reacts.
    task automatic fly(input string tag, input int k0, input int k1, input logic [10:0] x);
        logic [24:0] e;
        logic [24:0] g;
        for (int k = k0; k <= k1; k++) begin
            sb.push_back(pk(11'(440 - 4 * k), x, 1'b1, (k == 0), 1'b0));
            advance_frame();
            e = sb.pop_front();
            g = got_vec();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s k=%0d: got y=%0d x=%0d a=%b s=%b h=%b, want y=%0d x=%0d a=%b s=%b h=%b",
                         tag, k, g[24:14], g[13:3], g[2], g[1], g[0], e[24:14], e[13:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd2;
        repeat (3) tick();
        n_tests++;
        if (got_vec() !== pk(11'd2000, 11'd0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_state: got y=%0d x=%0d a=%b s=%b h=%b, want y=2000 x=0 a=0 s=0 h=0",
                     laser_y, laser_x, laser_active, shot_fired, laser_hit);
        end
        rst = 1'b0;
        xc = 10'd0; yc = 10'd0;
        #1;
        n_tests++;
        if ({is_laser, rgb} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_pixel: got is_laser=%b rgb=%h, want 0 00", is_laser, rgb);
        end
        xc = 10'd100; yc = 10'd100;
        tick();
    endtask

    task automatic test_launch_flight();
        logic [10:0] px[7] = '{11'd320, 11'd321, 11'd319, 11'd322, 11'd318, 11'd320, 11'd320};
        logic [10:0] py[7] = '{11'd428, 11'd433, 11'd423, 11'd428, 11'd428, 11'd434, 11'd422};
        logic        pe[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        ship_x = 11'd320;
        fire_pulse();
        fly("launch", 0, 0, 11'd320);
        tick();
        n_tests++;
        if (shot_fired !== 1'b0) begin
            n_fail++;
            $display("FAIL shot_pulse_width: got %b, want 0", shot_fired);
        end
        fly("flight", 1, 3, 11'd320);
        for (int i = 0; i < 7; i++) begin
            xc = px[i][9:0]; yc = py[i][9:0];
            #1;
            n_tests++;
            if ({is_laser, rgb} !== {pe[i], pe[i] ? 8'hff : 8'h00}) begin
                n_fail++;
                $display("FAIL pixel(%0d,%0d): got is_laser=%b rgb=%h, want %b", px[i], py[i], is_laser, rgb, pe[i]);
            end
        end
        xc = 10'd100; yc = 10'd100;
    endtask

    task automatic test_top_exit();
        logic [24:0] e;
        fly("to_top", 4, 108, 11'd320);
        sb.push_back(pk(11'd2000, 11'd320, 1'b0, 1'b0, 1'b0));
        advance_frame();
        e = sb.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
            n_fail++;
            $display("FAIL top_exit: got y=%0d a=%b h=%b, want y=2000 a=0 h=0", laser_y, laser_active, laser_hit);
        end
        settle();
        ship_x = 11'd100;
        fire_pulse();
        fly("refire", 0, 0, 11'd100);
    endtask

    task automatic test_hit();
        logic [24:0] e;
        fly("to_88", 1, 88, 11'd100);
        target_hit = 1'b1;
        sb.push_back(pk(11'd2000, 11'd100, 1'b0, 1'b0, 1'b1));
        advance_frame();
        target_hit = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
            n_fail++;
            $display("FAIL hit_at_88: got y=%0d a=%b h=%b, want y=2000 a=0 h=1", laser_y, laser_active, laser_hit);
        end
        tick();
        n_tests++;
        if (laser_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_pulse_width: got %b, want 0", laser_hit);
        end
        settle();
        target_hit = 1'b1;
        sb.push_back(pk(11'd2000, 11'd100, 1'b0, 1'b0, 1'b0));
        advance_frame();
        target_hit = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
            n_fail++;
            $display("FAIL hit_in_idle: got y=%0d a=%b h=%b, want y=2000 a=0 h=0", laser_y, laser_active, laser_hit);
        end
        ship_x = 11'd200;
        fire_pulse();
        fly("to_top_hit", 0, 108, 11'd200);
        target_hit = 1'b1;
        sb.push_back(pk(11'd2000, 11'd200, 1'b0, 1'b0, 1'b1));
        advance_frame();
        target_hit = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
            n_fail++;
            $display("FAIL hit_and_top: got y=%0d a=%b h=%b, want y=2000 a=0 h=1", laser_y, laser_active, laser_hit);
        end
        settle();
    endtask

    task automatic test_fire_in_fly();
        logic [24:0] e;
        ship_x = 11'd50;
        fire_pulse();
        fly("ff_launch", 0, 35, 11'd50);
        ship_x = 11'd60;
        fire_pulse();
        fly("ff_rest", 36, 108, 11'd50);
        for (int i = 0; i < 4; i++) begin
            sb.push_back(pk(11'd2000, 11'd50, 1'b0, 1'b0, 1'b0));
            if (i == 0) advance_frame();
            else        begin settle(); advance_frame(); end
            e = sb.pop_front();
            n_tests++;
            if (got_vec() !== e) begin
                n_fail++;
                $display("FAIL no_queued_fire i=%0d: got y=%0d x=%0d a=%b s=%b, want y=2000 x=50 a=0 s=0",
                         i, laser_y, laser_x, laser_active, shot_fired);
            end
        end
        fire_pulse();
        fly("mode_launch", 0, 3, 11'd60);
        mode = 2'd1;
        tick();
        n_tests++;
        if (got_vec() !== pk(11'd2000, 11'd0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL mode_park: got y=%0d x=%0d a=%b, want y=2000 x=0 a=0", laser_y, laser_x, laser_active);
        end
        mode = 2'd2;
        tick();
        fire_pulse();
        fly("restart_launch", 0, 1, 11'd60);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_tests++;
        if (got_vec() !== pk(11'd2000, 11'd0, 1'b0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL restart_park: got y=%0d x=%0d a=%b, want y=2000 x=0 a=0", laser_y, laser_x, laser_active);
        end
        tick();
    endtask

`ifdef SPACESHIP_LASER_COOLDOWN_EN
    task automatic test_cooldown();
        logic [24:0] e;
        ship_x = 11'd400;
        fire_pulse();
        fly("cd_flight", 0, 108, 11'd400);
        advance_frame();
        repeat (5) advance_frame();
        fire_pulse();
        sb.push_back(pk(11'd2000, 11'd400, 1'b0, 1'b0, 1'b0));
        advance_frame();
        e = sb.pop_front();
        n_tests++;
        if (got_vec() !== e) begin
            n_fail++;
            $display("FAIL cooldown_block: got y=%0d a=%b s=%b, want y=2000 a=0 s=0", laser_y, laser_active, shot_fired);
        end
        repeat (14) advance_frame();
        ship_x = 11'd410;
        fire_pulse();
        fly("cd_relaunch", 0, 0, 11'd410);
    endtask
`endif

    initial begin
        test_reset();
        test_launch_flight();
        test_top_exit();
        test_hit();
        test_fire_in_fly();
`ifdef SPACESHIP_LASER_COOLDOWN_EN
        test_cooldown();
`endif
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
